// File: rtl/ps2_pkg.sv
// Shared PS/2 host definitions: FSM encoding, abort codes, command bytes, time conversions.
// Latency: n/a (constants and constant functions only).
// Backpressure: n/a.
package ps2_pkg;

  // Host transmit FSM encoding
  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_INHIBIT   = 4'd1;
  localparam logic [3:0] ST_SETUP     = 4'd2;
  localparam logic [3:0] ST_WAIT_DEV  = 4'd3;
  localparam logic [3:0] ST_SHIFT     = 4'd4;
  localparam logic [3:0] ST_ACK       = 4'd5;
  localparam logic [3:0] ST_WAIT_IDLE = 4'd6;
  localparam logic [3:0] ST_DONE      = 4'd7;
  localparam logic [3:0] ST_ERR       = 4'd8;

  // Abort reasons reported on err_code
  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_START_TO = 2'd1;
  localparam logic [1:0] ERR_FRAME_TO = 2'd2;
  localparam logic [1:0] ERR_NACK     = 2'd3;

  // Common keyboard commands
  localparam logic [7:0] CMD_LED = 8'hED;
  localparam logic [7:0] CMD_EN  = 8'hF4;
  localparam logic [7:0] CMD_RST = 8'hFF;

  function automatic int us_to_cycles(input int us, input int clk_hz);
    return int'((longint'(us) * longint'(clk_hz)) / 64'd1_000_000);
  endfunction

  function automatic int ms_to_cycles(input int ms, input int clk_hz);
    return int'((longint'(ms) * longint'(clk_hz)) / 64'd1_000);
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises the PS/2 pads and debounces clk, emitting a one-cycle strobe on each filtered falling edge.
// Latency: 2 cycles for the synced levels; fall strobe 2 + FILTER_LEN cycles after the pad falls.
// Backpressure: none; free-running, the strobe is lost if the consumer ignores it.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_in,
  input  logic data_in,
  output logic clk_sync,
  output logic data_sync,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN) + 1;

  logic [1:0]    clk_ff;
  logic [1:0]    data_ff;
  logic [CW-1:0] cnt;
  logic          level;

  assign clk_sync  = clk_ff[1];
  assign data_sync = data_ff[1];

  // Two-flop synchronisers; idle bus level is high
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_ff  <= 2'b11;
      data_ff <= 2'b11;
    end else begin
      clk_ff  <= {clk_ff[0], clk_in};
      data_ff <= {data_ff[0], data_in};
    end
  end

  // Accept a new clk level only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b1;
      fall  <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_sync == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        cnt   <= '0;
        level <= clk_sync;
        fall  <= level;  // old level high means this change is 1 -> 0
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, start bit, 8 data bits LSB first, odd parity, stop, device ACK.
// Latency: accept to first line activity 1 cycle; whole frame is paced by the device clock (~1 ms).
// Backpressure: tx_ready only in IDLE; tx_valid outside IDLE is dropped, nothing is queued.
module ps2_host_tx import ps2_pkg::*; #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int INHIBIT_US  = 100,
  parameter int SETUP_US    = 5,
  parameter int START_TO_MS = 15,
  parameter int FRAME_TO_MS = 2,
  parameter int FILTER_LEN  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int INH_CYC   = us_to_cycles(INHIBIT_US, CLK_HZ);
  localparam int SETUP_CYC = us_to_cycles(SETUP_US, CLK_HZ);
  localparam int START_CYC = ms_to_cycles(START_TO_MS, CLK_HZ);
  localparam int FRAME_CYC = ms_to_cycles(FRAME_TO_MS, CLK_HZ);
  localparam int TW        = $clog2(START_CYC) + 1;

  // Timer holds (duration - 1) so a state lasts exactly its duration in cycles
  localparam logic [TW-1:0] INH_LD   = TW'(INH_CYC - 1);
  localparam logic [TW-1:0] SETUP_LD = TW'(SETUP_CYC - 1);
  localparam logic [TW-1:0] START_LD = TW'(START_CYC - 1);
  localparam logic [TW-1:0] FRAME_LD = TW'(FRAME_CYC - 1);

  logic [3:0]    state;
  logic [8:0]    sh;       // {parity, data}; ones shift in so the 10th edge releases data
  logic [3:0]    bitcnt;   // device falling edges seen in this frame
  logic [TW-1:0] timer;
  logic          clk_oe_q;
  logic          data_oe_q;
  logic [1:0]    err_code_q;
  logic          clk_sync;
  logic          data_sync;
  logic          fall;
  logic          tmo;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk       (clk),
    .rst       (rst),
    .clk_in    (ps2_clk_in),
    .data_in   (ps2_data_in),
    .clk_sync  (clk_sync),
    .data_sync (data_sync),
    .fall      (fall)
  );

  assign tmo         = (timer == '0);
  assign tx_ready    = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign done        = (state == ST_DONE);
  assign err         = (state == ST_ERR);
  assign err_code    = err_code_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

  // Frame sequencer: the frame timer is loaded on the first device edge and
  // deliberately keeps running through SHIFT, ACK and WAIT_IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      sh         <= '0;
      bitcnt     <= '0;
      timer      <= '0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          clk_oe_q  <= 1'b0;
          data_oe_q <= 1'b0;
          if (tx_valid) begin
            sh         <= {~^tx_data, tx_data};
            bitcnt     <= '0;
            err_code_q <= ERR_NONE;
            timer      <= INH_LD;
            clk_oe_q   <= 1'b1;
            state      <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          if (tmo) begin
            data_oe_q <= 1'b1;  // start bit
            timer     <= SETUP_LD;
            state     <= ST_SETUP;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_SETUP: begin
          if (tmo) begin
            clk_oe_q <= 1'b0;   // hand the clock to the device
            timer    <= START_LD;
            state    <= ST_WAIT_DEV;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_WAIT_DEV: begin
          if (fall) begin
            data_oe_q <= ~sh[0];
            sh        <= {1'b1, sh[8:1]};
            bitcnt    <= 4'd1;
            timer     <= FRAME_LD;
            state     <= ST_SHIFT;
          end else if (tmo) begin
            data_oe_q  <= 1'b0;
            err_code_q <= ERR_START_TO;
            state      <= ST_ERR;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_SHIFT: begin
          if (tmo) begin
            data_oe_q  <= 1'b0;
            err_code_q <= ERR_FRAME_TO;
            state      <= ST_ERR;
          end else begin
            timer <= timer - 1'b1;
            if (fall) begin
              data_oe_q <= ~sh[0];  // data, parity, then the shifted-in stop level
              sh        <= {1'b1, sh[8:1]};
              bitcnt    <= bitcnt + 1'b1;
              if (bitcnt == 4'd9) state <= ST_ACK;
            end
          end
        end
        ST_ACK: begin
          if (tmo) begin
            err_code_q <= ERR_FRAME_TO;
            state      <= ST_ERR;
          end else begin
            timer <= timer - 1'b1;
            if (fall) begin
              if (!data_sync) begin
                state <= ST_WAIT_IDLE;
              end else begin
                err_code_q <= ERR_NACK;
                state      <= ST_ERR;
              end
            end
          end
        end
        ST_WAIT_IDLE: begin
          if (tmo) begin
            err_code_q <= ERR_FRAME_TO;
            state      <= ST_ERR;
          end else begin
            timer <= timer - 1'b1;
            if (clk_sync && data_sync) state <= ST_DONE;
          end
        end
        ST_DONE, ST_ERR: begin
          clk_oe_q  <= 1'b0;
          data_oe_q <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          clk_oe_q  <= 1'b0;
          data_oe_q <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural keyboard clocks frames out of the host and a reference
// model derives the expected bit stream from the byte; the clock rate is scaled to 1 MHz.
// Timeouts, NACK, mid-frame reset and ignored requests are exercised alongside random bytes.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int CLK_HZ    = 1_000_000;
  localparam int INH_CYC   = 100;     // 100 us at 1 MHz
  localparam int START_CYC = 15_000;  // 15 ms
  localparam int FRAME_CYC = 2_000;   // 2 ms
  localparam int HALF      = 20;      // half of a 40 us keyboard clock

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, done, err;
  logic [1:0] err_code;
  logic       clk_oe, data_oe;
  logic       kb_clk_low = 1'b0;
  logic       kb_data_low = 1'b0;
  wire        pad_clk  = ~(clk_oe | kb_clk_low);
  wire        pad_data = ~(data_oe | kb_data_low);

  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  int         n_done = 0;
  int         n_err = 0;
  int         t_err = 0;
  logic [1:0] err_code_seen = 2'b00;
  logic [1:0] err_oe_seen = 2'b00;

  ps2_host_tx #(
    .CLK_HZ(CLK_HZ), .INHIBIT_US(100), .SETUP_US(5),
    .START_TO_MS(15), .FRAME_TO_MS(2), .FILTER_LEN(8)
  ) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .done(done), .err(err), .err_code(err_code),
    .ps2_clk_in(pad_clk), .ps2_data_in(pad_data),
    .ps2_clk_oe(clk_oe), .ps2_data_oe(data_oe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log for done/err pulses, sampled away from the active edge
  always @(negedge clk) begin
    if (done) n_done <= n_done + 1;
    if (err) begin
      n_err         <= n_err + 1;
      t_err         <= cyc;
      err_code_seen <= err_code;
      err_oe_seen   <= {clk_oe, data_oe};
    end
  end

  initial begin
    #600_000;
    $display("FAIL watchdog: simulation did not complete, got hang want finish");
    $fatal(1);
  end

  // Expected line levels sampled by the keyboard on rising edges 1..10
  function automatic logic [9:0] ref_frame(input logic [7:0] b);
    int ones;
    logic [9:0] f;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      f[i] = b[i];
      ones += int'(b[i]);
    end
    f[8] = ((ones % 2) == 0);  // odd parity over data+parity
    f[9] = 1'b1;               // stop
    return f;
  endfunction

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Keyboard: waits for the start bit, then clocks n_edges falls; ACKs on edge 11 if asked
  task automatic kb_run(input int n_edges, input bit ack, output logic [9:0] cap,
                        output int t_fall1, output bit started);
    int w;
    cap = '0; t_fall1 = 0; w = 0;
    while (!(pad_clk && !pad_data) && w < 2000) begin @(negedge clk); w++; end
    started = (pad_clk && !pad_data);
    if (!started) return;
    repeat (30) @(negedge clk);
    for (int e = 1; e <= n_edges; e++) begin
      kb_clk_low = 1'b1;
      if (e == 1) t_fall1 = cyc;
      repeat (HALF) @(negedge clk);
      kb_clk_low = 1'b0;
      if (e <= 10) cap[e-1] = pad_data;
      if (e == 11) begin
        kb_data_low = 1'b0;
        break;
      end
      repeat (HALF/2) @(negedge clk);
      if (e == 10 && ack) kb_data_low = 1'b1;
      repeat (HALF/2) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({tx_ready, busy, done, err, err_code, clk_oe, data_oe} !== 8'b1000_0000) begin
      n_fail++;
      $display("FAIL reset_state: got %b want 10000000",
               {tx_ready, busy, done, err, err_code, clk_oe, data_oe});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_frame(input string name, input logic [7:0] b, input bit poke);
    logic [9:0] cap, exp_f;
    int t1, w, inh_len, stray, d0, e0;
    bit st;
    d0 = n_done; e0 = n_err; inh_len = 0; stray = 0; exp_f = ref_frame(b);
    fork
      begin
        send(b);
        if (poke) begin
          repeat (10) @(negedge clk);
          tx_data = ~b; tx_valid = 1'b1;
          @(negedge clk);
          tx_valid = 1'b0;
        end
      end
      kb_run(11, 1'b1, cap, t1, st);
      begin
        w = 0;
        while (!clk_oe && w < 20) begin @(negedge clk); w++; end
        while (clk_oe && !data_oe && inh_len < 5000) begin @(negedge clk); inh_len++; end
      end
    join
    w = 0;
    while (n_done == d0 && n_err == e0 && w < 300) begin @(negedge clk); w++; end
    n_tests++;
    if (!st) begin n_fail++; $display("FAIL %s_start: got no start bit want start bit", name); end
    n_tests++;
    if (cap !== exp_f) begin
      n_fail++; $display("FAIL %s_bits: got %b want %b (stop,parity,d7..d0)", name, cap, exp_f);
    end
    n_tests++;
    if (n_done != d0 + 1 || n_err != e0) begin
      n_fail++; $display("FAIL %s_outcome: got done=%0d err=%0d want done=1 err=0", name, n_done - d0, n_err - e0);
    end
    n_tests++;
    if ({done, busy, tx_ready, err_code} !== 5'b00100) begin
      n_fail++; $display("FAIL %s_after: got %b want 00100", name, {done, busy, tx_ready, err_code});
    end
    if (poke) begin
      n_tests++;
      if (inh_len < INH_CYC) begin
        n_fail++; $display("FAIL %s_inhibit: got %0d cycles want >= %0d", name, inh_len, INH_CYC);
      end
      repeat (200) begin @(negedge clk); if (clk_oe || busy) stray++; end
      n_tests++;
      if (stray != 0) begin
        n_fail++; $display("FAIL %s_ignored_req: got %0d busy cycles want 0", name, stray);
      end
    end
  endtask

  task automatic test_start_timeout();
    int w, t_rel, d0, e0, delta;
    d0 = n_done; e0 = n_err; t_rel = 0;
    fork
      send(CMD_EN);
      begin
        w = 0;
        while (!clk_oe && w < 20) begin @(negedge clk); w++; end
        while (clk_oe && w < 500) begin @(negedge clk); w++; end
        t_rel = cyc;
      end
    join
    w = 0;
    while (n_err == e0 && w < START_CYC + 200) begin @(negedge clk); w++; end
    delta = t_err - t_rel;
    n_tests++;
    if (n_err != e0 + 1 || n_done != d0) begin
      n_fail++; $display("FAIL start_to_outcome: got err=%0d done=%0d want err=1 done=0", n_err - e0, n_done - d0);
    end
    n_tests++;
    if (delta < START_CYC - 1 || delta > START_CYC + 1) begin
      n_fail++; $display("FAIL start_to_time: got %0d cycles want %0d +/-1", delta, START_CYC);
    end
    n_tests++;
    if (err_code_seen !== ERR_START_TO || err_oe_seen !== 2'b00) begin
      n_fail++; $display("FAIL start_to_code: got code=%0d oe=%b want code=1 oe=00", err_code_seen, err_oe_seen);
    end
    n_tests++;
    if (err_code !== 2'd1 || tx_ready !== 1'b1) begin
      n_fail++; $display("FAIL start_to_hold: got code=%0d ready=%b want code=1 ready=1", err_code, tx_ready);
    end
  endtask

  task automatic test_frame_timeout();
    logic [9:0] cap;
    int t1, w, d0, e0, delta;
    bit st;
    d0 = n_done; e0 = n_err;
    fork
      send(CMD_LED);
      kb_run(5, 1'b1, cap, t1, st);
    join
    w = 0;
    while (n_err == e0 && w < FRAME_CYC + 500) begin @(negedge clk); w++; end
    delta = t_err - t1;
    n_tests++;
    if (n_err != e0 + 1 || n_done != d0 || err_code_seen !== ERR_FRAME_TO) begin
      n_fail++; $display("FAIL frame_to_code: got err=%0d code=%0d want err=1 code=2", n_err - e0, err_code_seen);
    end
    n_tests++;
    if (delta < FRAME_CYC || delta > FRAME_CYC + 20) begin
      n_fail++; $display("FAIL frame_to_time: got %0d cycles want %0d..%0d", delta, FRAME_CYC, FRAME_CYC + 20);
    end
    n_tests++;
    if (err_oe_seen !== 2'b00) begin
      n_fail++; $display("FAIL frame_to_oe: got %b want 00", err_oe_seen);
    end
  endtask

  task automatic test_nack();
    logic [9:0] cap;
    int t1, w, d0, e0;
    bit st;
    d0 = n_done; e0 = n_err;
    fork
      send(CMD_LED);
      kb_run(11, 1'b0, cap, t1, st);
    join
    w = 0;
    while (n_err == e0 && w < 300) begin @(negedge clk); w++; end
    n_tests++;
    if (n_err != e0 + 1 || n_done != d0 || err_code_seen !== ERR_NACK) begin
      n_fail++; $display("FAIL nack_code: got err=%0d code=%0d want err=1 code=3", n_err - e0, err_code_seen);
    end
    n_tests++;
    if (cap !== ref_frame(CMD_LED)) begin
      n_fail++; $display("FAIL nack_bits: got %b want %b", cap, ref_frame(CMD_LED));
    end
    repeat (5) @(negedge clk);
    n_tests++;
    if (err_code !== 2'd3) begin
      n_fail++; $display("FAIL nack_hold: got %0d want 3", err_code);
    end
    test_frame("after_nack", CMD_RST, 1'b0);
  endtask

  task automatic test_reset_midframe();
    logic [9:0] cap;
    int t1, d0, e0, stray;
    bit st;
    d0 = n_done; e0 = n_err; stray = 0;
    fork
      send(CMD_LED);
      kb_run(6, 1'b1, cap, t1, st);
    join
    n_tests++;
    if ({busy, tx_ready} !== 2'b10) begin
      n_fail++; $display("FAIL mid_busy: got %b want 10", {busy, tx_ready});
    end
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({clk_oe, data_oe, tx_ready} !== 3'b001) begin
      n_fail++; $display("FAIL mid_reset: got %b want 001", {clk_oe, data_oe, tx_ready});
    end
    rst = 1'b0;
    repeat (300) begin @(negedge clk); if (clk_oe || busy) stray++; end
    n_tests++;
    if (stray != 0 || n_done != d0 || n_err != e0) begin
      n_fail++; $display("FAIL mid_quiet: got busy=%0d done=%0d err=%0d want 0 0 0", stray, n_done - d0, n_err - e0);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom_range(0, 255));
      test_frame($sformatf("rand%0d", i), b, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_frame("led", CMD_LED, 1'b0);
    test_frame("enable", CMD_EN, 1'b1);
    test_start_timeout();
    test_frame_timeout();
    test_nack();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
